conv1d_sequencer: RTL

- Multi-cycle controller and MAC engine for the CFU 1-D convolution: kernel length 8, output position out_x reads input positions out_x-3 .. out_x+4, zero padding outside [0, width).
- For each output position it walks filter_x then in_channel over the external input and kernel RAMs, accumulates, adds bias and writes one word to the output RAM.
- Sits between the CFU command decoder (start/abort/config) and the three buffer RAMs. Replaces the single-cycle unrolled compute loop.

---
 rtl/conv1d_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: multi-cycle 1-D convolution controller and MAC engine.
// One tap per cycle over (filter_x outer, channel inner), kernel origin at -3,
// zero padding outside [0, width), then one output word of acc + bias.
module conv1d_sequencer #(
    parameter int unsigned MAX_WIDTH     = 1024,
    parameter int unsigned MAX_DEPTH     = 128,
    parameter int unsigned KERNEL_LENGTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [10:0] cfg_width,
    input  logic [7:0]  cfg_depth,
    input  logic [31:0] cfg_input_offset,
    input  logic [31:0] cfg_bias,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        in_rd_en,
    output logic [16:0] in_rd_addr,
    input  logic [7:0]  in_rd_data,
    output logic        kw_rd_en,
    output logic [9:0]  kw_rd_addr,
    input  logic [7:0]  kw_rd_data,
    output logic        out_wr_en,
    output logic [9:0]  out_wr_addr,
    output logic [31:0] out_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [2:0]  LAST_TAP  = 3'(KERNEL_LENGTH - 1);
    localparam logic [10:0] MAX_W     = 11'(MAX_WIDTH);
    localparam logic [7:0]  MAX_D     = 8'(MAX_DEPTH);

    state_e      state_q, state_d;
    logic [10:0] width_q, width_d;
    logic [7:0]  depth_q, depth_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] bias_q, bias_d;
    logic [10:0] out_x_q, out_x_d;
    logic [2:0]  filter_x_q, filter_x_d;
    logic [7:0]  ch_q, ch_d;
    logic [31:0] acc_q, acc_d;
    logic        vld_q, vld_d;
    logic        error_q, error_d;

    logic               cfg_ok;
    logic signed [12:0] in_x;
    logic               tap_in_range;
    logic [31:0]        in_ext;
    logic [31:0]        kw_ext;
    logic [31:0]        prod;

    // Tap position, padding test and the product for the tap issued last cycle
    always_comb begin
        cfg_ok       = (cfg_width != '0) && (cfg_width <= MAX_W) &&
                       (cfg_depth != '0) && (cfg_depth <= MAX_D);
        in_x         = $signed({2'b00, out_x_q}) - 13'sd3 + $signed({10'b0, filter_x_q});
        tap_in_range = !in_x[12] && (in_x[11:0] < {1'b0, width_q});
        in_ext       = {{24{in_rd_data[7]}}, in_rd_data};
        kw_ext       = {{24{kw_rd_data[7]}}, kw_rd_data};
        prod         = kw_ext * (in_ext + offset_q);
    end

    // Next-state, counters and accumulator
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        depth_d    = depth_q;
        offset_d   = offset_q;
        bias_d     = bias_q;
        out_x_d    = out_x_q;
        filter_x_d = filter_x_q;
        ch_d       = ch_q;
        acc_d      = vld_q ? (acc_q + prod) : acc_q;
        vld_d      = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        width_d    = cfg_width;
                        depth_d    = cfg_depth;
                        offset_d   = cfg_input_offset;
                        bias_d     = cfg_bias;
                        out_x_d    = '0;
                        filter_x_d = '0;
                        ch_d       = '0;
                        acc_d      = '0;
                        state_d    = S_ISSUE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                vld_d = tap_in_range;
                if (ch_q == depth_q - 8'd1) begin
                    ch_d = '0;
                    if (filter_x_q == LAST_TAP) begin
                        filter_x_d = '0;
                        state_d    = S_DRAIN;
                    end else begin
                        filter_x_d = filter_x_q + 3'd1;
                    end
                end else begin
                    ch_d = ch_q + 8'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_d = '0;
                if (out_x_q < width_q - 11'd1) begin
                    out_x_d = out_x_q + 11'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            acc_d   = '0;
            vld_d   = 1'b0;
        end
    end

    // Output decode from current state and counters
    always_comb begin
        busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_WRITE);
        done        = (state_q == S_DONE);
        error       = error_q;
        in_rd_en    = 1'b0;
        kw_rd_en    = 1'b0;
        in_rd_addr  = '0;
        kw_rd_addr  = '0;
        out_wr_en   = 1'b0;
        out_wr_addr = '0;
        out_wr_data = '0;
        if ((state_q == S_ISSUE) && tap_in_range) begin
            in_rd_en   = 1'b1;
            kw_rd_en   = 1'b1;
            in_rd_addr = 17'(in_x[10:0]) * 17'(depth_q) + 17'(ch_q);
            kw_rd_addr = 10'(filter_x_q) * 10'(depth_q) + 10'(ch_q);
        end
        if (state_q == S_WRITE) begin
            out_wr_en   = 1'b1;
            out_wr_addr = out_x_q[9:0];
            out_wr_data = acc_q + bias_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            depth_q    <= '0;
            offset_q   <= '0;
            bias_q     <= '0;
            out_x_q    <= '0;
            filter_x_q <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            vld_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            depth_q    <= depth_d;
            offset_q   <= offset_d;
            bias_q     <= bias_d;
            out_x_q    <= out_x_d;
            filter_x_q <= filter_x_d;
            ch_q       <= ch_d;
            acc_q      <= acc_d;
            vld_q      <= vld_d;
            error_q    <= error_d;
        end
    end

endmodule
